// File: rtl/dot_arbiter_if.sv
// Bundle between the dot arbiter and its neighbours: requester operand FIFOs,
// the shared dot unit's input/output FIFOs, requester result FIFOs and status.
interface dot_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int D_BITS = 32
);
  logic [N_REQ-1:0]                   req_empty;
  logic [N_REQ-1:0]                   req_rd_en;
  logic [N_REQ-1:0][2:0][D_BITS-1:0]  req_x;
  logic [N_REQ-1:0][2:0][D_BITS-1:0]  req_y;
  logic [2:0][D_BITS-1:0]             dot_x;
  logic [2:0][D_BITS-1:0]             dot_y;
  logic                               dot_in_empty;
  logic                               dot_in_rd_en;
  logic [D_BITS-1:0]                  dot_out;
  logic                               dot_out_empty;
  logic                               dot_out_rd_en;
  logic [D_BITS-1:0]                  res_dout;
  logic [N_REQ-1:0]                   res_full;
  logic [N_REQ-1:0]                   res_wr_en;
  logic                               busy;
  logic                               err_orphan;

  modport slave (
    input  req_empty, req_x, req_y, dot_in_rd_en, dot_out, dot_out_empty, res_full,
    output req_rd_en, dot_x, dot_y, dot_in_empty, dot_out_rd_en, res_dout, res_wr_en,
           busy, err_orphan
  );

  modport master (
    output req_empty, req_x, req_y, dot_in_rd_en, dot_out, dot_out_empty, res_full,
    input  req_rd_en, dot_x, dot_y, dot_in_empty, dot_out_rd_en, res_dout, res_wr_en,
           busy, err_orphan
  );
endinterface

// File: rtl/dot_arbiter.sv
// Round-robin sharing of one dot unit; issue 1 cycle after req_empty falls, one op per 2 cycles.
// Results return in issue order via a requester-id tag FIFO; a full result FIFO stalls only returns.
module dot_arbiter #(
  parameter int N_REQ     = 4,
  parameter int D_BITS    = 32,
  parameter int TAG_DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  dot_arbiter_if.slave io_bus
);
  localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_ARB, S_HOLD} issue_state_t;
  typedef enum logic {S_RIDLE, S_RWRITE} ret_state_t;

  issue_state_t           r_issue_state, w_issue_next;
  ret_state_t             r_ret_state, w_ret_next;
  logic [TAG_W-1:0]       r_rr_ptr;
  logic [2:0][D_BITS-1:0] r_dot_x, r_dot_y;
  logic [TAG_W-1:0]       r_tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]       r_tag_wr_ptr, r_tag_rd_ptr;
  logic [CNT_W-1:0]       r_tag_cnt;
  logic [D_BITS-1:0]      r_res_dout;
  logic [TAG_W-1:0]       r_res_tag;
  logic                   r_err_orphan;

  logic                   w_grant_vld;
  logic [TAG_W-1:0]       w_grant_idx, w_cand;
  logic                   w_tag_full, w_tag_empty;
  logic                   w_issue, w_pop, w_orphan;
  logic                   w_dot_in_empty;
  logic [N_REQ-1:0]       w_req_rd_en, w_res_wr_en;

  function automatic logic [TAG_W-1:0] wrap_add(input logic [TAG_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return sum[TAG_W-1:0];
  endfunction

  // Scan downward so the candidate closest to the rr pointer wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = wrap_add(r_rr_ptr, k);
      if (!io_bus.req_empty[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  assign w_tag_full  = (r_tag_cnt == CNT_W'(TAG_DEPTH));
  assign w_tag_empty = (r_tag_cnt == '0);

  // Pulses are masked while reset is held so no FIFO pops during reset.
  always_comb begin
    w_issue_next   = r_issue_state;
    w_issue        = 1'b0;
    w_req_rd_en    = '0;
    w_dot_in_empty = 1'b1;
    case (r_issue_state)
      S_ARB: begin
        if (!reset && w_grant_vld && !w_tag_full) begin
          w_issue                  = 1'b1;
          w_req_rd_en[w_grant_idx] = 1'b1;
          w_issue_next             = S_HOLD;
        end
      end
      S_HOLD: begin
        w_dot_in_empty = 1'b0;
        if (io_bus.dot_in_rd_en) w_issue_next = S_ARB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_issue_state <= S_ARB;
      r_rr_ptr      <= '0;
      r_dot_x       <= '0;
      r_dot_y       <= '0;
    end else begin
      r_issue_state <= w_issue_next;
      if (w_issue) begin
        r_rr_ptr <= wrap_add(w_grant_idx, 1);
        r_dot_x  <= io_bus.req_x[w_grant_idx];
        r_dot_y  <= io_bus.req_y[w_grant_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_issue) r_tag_mem[r_tag_wr_ptr] <= w_grant_idx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tag_wr_ptr <= '0;
      r_tag_rd_ptr <= '0;
      r_tag_cnt    <= '0;
    end else begin
      if (w_issue) r_tag_wr_ptr <= r_tag_wr_ptr + PTR_W'(1);
      if (w_pop)   r_tag_rd_ptr <= r_tag_rd_ptr + PTR_W'(1);
      if (w_issue && !w_pop)      r_tag_cnt <= r_tag_cnt + CNT_W'(1);
      else if (!w_issue && w_pop) r_tag_cnt <= r_tag_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_ret_next  = r_ret_state;
    w_pop       = 1'b0;
    w_orphan    = 1'b0;
    w_res_wr_en = '0;
    case (r_ret_state)
      S_RIDLE: begin
        if (!reset && !io_bus.dot_out_empty) begin
          if (!w_tag_empty) begin
            w_pop      = 1'b1;
            w_ret_next = S_RWRITE;
          end else begin
            w_orphan = 1'b1;
          end
        end
      end
      S_RWRITE: begin
        if (!io_bus.res_full[r_res_tag]) begin
          w_res_wr_en[r_res_tag] = 1'b1;
          w_ret_next             = S_RIDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ret_state  <= S_RIDLE;
      r_res_dout   <= '0;
      r_res_tag    <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_ret_state <= w_ret_next;
      if (w_pop) begin
        r_res_dout <= io_bus.dot_out;
        r_res_tag  <= r_tag_mem[r_tag_rd_ptr];
      end
      if (w_orphan) r_err_orphan <= 1'b1;
    end
  end

  assign io_bus.req_rd_en     = w_req_rd_en;
  assign io_bus.dot_x         = r_dot_x;
  assign io_bus.dot_y         = r_dot_y;
  assign io_bus.dot_in_empty  = w_dot_in_empty;
  assign io_bus.dot_out_rd_en = w_pop;
  assign io_bus.res_dout      = r_res_dout;
  assign io_bus.res_wr_en     = w_res_wr_en;
  assign io_bus.busy          = !w_tag_empty || (r_issue_state != S_ARB);
  assign io_bus.err_orphan    = r_err_orphan;
endmodule

// File: tb/tb_dot_arbiter.sv
// Bench for dot_arbiter: requester FIFOs and an in-order Q16 dot unit are modelled with queues;
// a monitor checks grants against round-robin rules and results against per-requester expectations.
module tb_dot_arbiter;
  localparam int N  = 4;
  localparam int D  = 32;
  localparam int TD = 16;

  typedef struct packed {
    logic [2:0][D-1:0] x;
    logic [2:0][D-1:0] y;
  } op_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dot_arbiter_if #(.N_REQ(N), .D_BITS(D)) bus ();

  dot_arbiter #(.N_REQ(N), .D_BITS(D), .TAG_DEPTH(TD)) dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus)
  );

  op_t          req_q [N][$];
  logic [D-1:0] exp_q [N][$];
  logic [D-1:0] dq_val [$];
  int           dq_rdy [$];

  bit           hold_out = 0;
  bit           force_orphan = 0;
  int           cons_pct = 100;
  int           full_pct = 0;
  logic [N-1:0] full_force = '0;
  logic [N-1:0] hide = '0;

  logic [N-1:0] act_rd = '0;
  bit           act_cons = 0;
  bit           act_pop = 0;
  logic [D-1:0] act_val = '0;
  int           cyc = 0;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           grants = 0;
  int           grant_log [$];
  int           wr_log [$];
  logic [D-1:0] last_wr = '0;
  int           m_rr = 0;
  int           m_out = 0;

  function automatic logic [D-1:0] dot_ref(input logic [2:0][D-1:0] x, input logic [2:0][D-1:0] y);
    longint acc;
    acc = 0;
    for (int i = 0; i < 3; i++)
      acc += (longint'($signed(x[i])) * longint'($signed(y[i]))) >>> 16;
    return acc[D-1:0];
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, want 'h%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic add_op(input int r, input op_t op);
    req_q[r].push_back(op);
    exp_q[r].push_back(dot_ref(op.x, op.y));
  endtask

  function automatic op_t rand_op();
    op_t op;
    for (int i = 0; i < 3; i++) begin
      op.x[i] = $urandom;
      op.y[i] = $urandom;
    end
    return op;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (req_q[i].size() > 0 && !hide[i]) begin
        bus.req_empty[i] = 1'b0;
        bus.req_x[i]     = req_q[i][0].x;
        bus.req_y[i]     = req_q[i][0].y;
      end else begin
        bus.req_empty[i] = 1'b1;
        bus.req_x[i]     = '0;
        bus.req_y[i]     = '0;
      end
      bus.res_full[i] = full_force[i] | (int'($urandom_range(0, 99)) < full_pct);
    end
    if (force_orphan) begin
      bus.dot_out_empty = 1'b0;
      bus.dot_out       = 32'hdead_beef;
    end else if (!hold_out && dq_val.size() > 0 && dq_rdy[0] <= cyc) begin
      bus.dot_out_empty = 1'b0;
      bus.dot_out       = dq_val[0];
    end else begin
      bus.dot_out_empty = 1'b1;
      bus.dot_out       = '0;
    end
    bus.dot_in_rd_en = !bus.dot_in_empty && (int'($urandom_range(0, 99)) < cons_pct);
  endtask

  // Apply what the previous edge did, present new inputs, then record what the next edge will do.
  task automatic tick();
    @(negedge clock);
    cyc++;
    for (int i = 0; i < N; i++)
      if (act_rd[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
    if (act_pop && dq_val.size() > 0) begin
      void'(dq_val.pop_front());
      void'(dq_rdy.pop_front());
    end
    if (act_cons) begin
      dq_val.push_back(act_val);
      dq_rdy.push_back(cyc + int'($urandom_range(0, 4)));
    end
    drive();
    #1;
    act_rd   = bus.req_rd_en;
    act_cons = bus.dot_in_rd_en && !bus.dot_in_empty;
    act_val  = dot_ref(bus.dot_x, bus.dot_y);
    act_pop  = bus.dot_out_rd_en;
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++)
      if (req_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return dq_val.size() == 0 && !bus.busy && bus.res_wr_en == '0 && bus.dot_in_empty;
  endfunction

  task automatic wait_idle(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      tick();
      done = drained();
    end
    chk("drain_in_time", done, 1'b1);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_q[i].delete();
      exp_q[i].delete();
    end
    dq_val.delete();
    dq_rdy.delete();
    act_rd = '0; act_cons = 0; act_pop = 0;
    hold_out = 0; force_orphan = 0; full_force = '0; hide = '0;
    full_pct = 0; cons_pct = 100;
    grants = 0; grant_log.delete(); wr_log.delete();
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string t);
    chk({t, "_dot_in_empty"}, bus.dot_in_empty, 1'b1);
    chk({t, "_req_rd_en"}, bus.req_rd_en, '0);
    chk({t, "_res_wr_en"}, bus.res_wr_en, '0);
    chk({t, "_dot_out_rd_en"}, bus.dot_out_rd_en, 1'b0);
    chk({t, "_busy"}, bus.busy, 1'b0);
    chk({t, "_err_orphan"}, bus.err_orphan, 1'b0);
    chk({t, "_dot_x"}, bus.dot_x, '0);
    chk({t, "_dot_y"}, bus.dot_y, '0);
    chk({t, "_res_dout"}, bus.res_dout, '0);
  endtask

  // Scoreboard monitor: grants vs round-robin rule and tag capacity, writes vs expected results.
  initial begin
    int g, e, w;
    bit found;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        m_rr  = 0;
        m_out = 0;
      end else begin
        if (bus.req_rd_en != '0) begin
          g = 0;
          for (int i = 0; i < N; i++) if (bus.req_rd_en[i]) g = i;
          e = -1;
          found = 1'b0;
          for (int k = 0; k < N; k++)
            if (!found && !bus.req_empty[(m_rr + k) % N]) begin
              e = (m_rr + k) % N;
              found = 1'b1;
            end
          chk("rd_onehot", $countones(bus.req_rd_en), 1);
          chk("rr_grant", g, e);
          chk("tag_room", m_out < TD, 1'b1);
          m_out++;
          m_rr = (g + 1) % N;
          grants++;
          grant_log.push_back(g);
        end
        if (bus.dot_out_rd_en) m_out--;
        if (bus.res_wr_en != '0) begin
          w = 0;
          for (int i = 0; i < N; i++) if (bus.res_wr_en[i]) w = i;
          chk("wr_onehot", $countones(bus.res_wr_en), 1);
          chk("wr_not_full", bus.res_full[w], 1'b0);
          if (exp_q[w].size() == 0) chk("wr_expected", 1'b0, 1'b1);
          else chk("res_val", bus.res_dout, exp_q[w].pop_front());
          wr_log.push_back(w);
          last_wr = bus.res_dout;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t          op;
    logic [D-1:0] v0, e_val;
    bit           reached;
    int           total;

    // Reset values
    repeat (2) tick();
    check_reset_vals("init");
    reset = 1'b0;

    // Single op on requester 1
    do_reset();
    op.x = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    op.y = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    add_op(1, op);
    tick();
    chk("single_grant", bus.req_rd_en, 4'b0010);
    chk("single_pre_in_empty", bus.dot_in_empty, 1'b1);
    tick();
    chk("issue_latency", bus.dot_in_empty, 1'b0);
    chk("single_dot_x", bus.dot_x, op.x);
    chk("single_dot_y", bus.dot_y, op.y);
    wait_idle(200);
    chk("single_grants", grant_log.size(), 1);
    chk("single_wr_cnt", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("single_wr_idx", wr_log[0], 1);
    chk("single_val", last_wr, 32'h0006_0000);
    chk("single_busy", bus.busy, 1'b0);

    // Round robin: two distinct ops per requester
    do_reset();
    for (int r = 0; r < N; r++)
      for (int n = 0; n < 2; n++) begin
        op = rand_op();
        op.x[0] = {8'(r), 8'(n), 16'h0};
        add_op(r, op);
      end
    wait_idle(400);
    chk("rr_grant_cnt", grant_log.size(), 8);
    chk("rr_wr_cnt", wr_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size()) chk("rr_order", grant_log[i], i % N);
      if (i < wr_log.size()) chk("rr_wr_order", wr_log[i], i % N);
    end

    // Backpressure on requester 2 with requester 3 queued behind
    do_reset();
    full_force = 4'b0100;
    add_op(2, rand_op());
    add_op(3, rand_op());
    e_val = exp_q[2][0];
    repeat (12) tick();
    v0 = bus.res_dout;
    chk("bp_pending_val", v0, e_val);
    repeat (10) tick();
    chk("bp_hold_val", bus.res_dout, v0);
    chk("bp_no_wr", wr_log.size(), 0);
    chk("bp_grants", grants, 2);
    full_force = '0;
    wait_idle(200);
    chk("bp_wr_cnt", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("bp_first", wr_log[0], 2);
      chk("bp_second", wr_log[1], 3);
    end

    // Tag FIFO full
    do_reset();
    hold_out = 1;
    full_force = '1;
    for (int r = 0; r < N; r++)
      for (int n = 0; n < 5; n++) add_op(r, rand_op());
    repeat (50) tick();
    chk("tagfull_grants", grants, 16);
    chk("tagfull_no_rd", bus.req_rd_en, '0);
    hold_out = 0;
    repeat (15) tick();
    chk("tagfull_17th", grants, 17);
    full_force = '0;
    wait_idle(1000);
    chk("tagfull_wr_total", wr_log.size(), 20);

    // Orphan result
    do_reset();
    force_orphan = 1;
    tick();
    chk("orphan_no_pop", bus.dot_out_rd_en, 1'b0);
    chk("orphan_pre", bus.err_orphan, 1'b0);
    tick();
    chk("orphan_set", bus.err_orphan, 1'b1);
    chk("orphan_no_pop2", bus.dot_out_rd_en, 1'b0);
    force_orphan = 0;
    repeat (5) tick();
    chk("orphan_sticky", bus.err_orphan, 1'b1);
    do_reset();
    chk("orphan_cleared", bus.err_orphan, 1'b0);

    // Reset in HOLD with three tags outstanding
    hold_out = 1;
    for (int r = 0; r < N; r++) add_op(r, rand_op());
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick();
      reached = (grants == 3) && !bus.dot_in_empty;
    end
    chk("midop_reached", reached, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_vals("midop");
    do_reset();
    op = rand_op();
    e_val = dot_ref(op.x, op.y);
    add_op(3, op);
    wait_idle(200);
    chk("midop_wr_cnt", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("midop_wr_idx", wr_log[0], 3);
    chk("midop_val", last_wr, e_val);

    // Randomized traffic with stalls on every side
    do_reset();
    cons_pct = 60;
    full_pct = 20;
    total = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        add_op(int'($urandom_range(0, N - 1)), rand_op());
        total++;
      end
      for (int i = 0; i < N; i++) hide[i] = ($urandom_range(0, 99) < 20);
      tick();
    end
    hide = '0;
    full_pct = 0;
    cons_pct = 100;
    wait_idle(4000);
    chk("rand_wr_total", wr_log.size(), total);
    chk("rand_grant_total", grants, total);
    chk("rand_no_orphan", bus.err_orphan, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dot_arbiter.md
Name: dot_arbiter

Overview:
- Shares one `dot` unit (FIFO-fronted, fixed-point 3-vector dot product) between N_REQ requesters.
- Each requester presents operands through a FIFO-style read interface: data valid while `!empty`; `rd_en` pops.
- The arbiter grants round-robin, issues operands to the shared unit, and records each requester id in an internal tag FIFO.
- It routes each result back in order to the requester that issued it. It sits between the ray-stage operand FIFOs and the single dot instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- D_BITS, 32, operand/result width (signed fixed point, passed through untouched).
- TAG_DEPTH, 16, tag FIFO entries; maximum number of operations in flight inside the dot unit and its output FIFO (power of 2).

Ports:
- clock  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_empty  in  N_REQ  per-requester operand FIFO empty.
- req_rd_en  out  N_REQ  per-requester pop, one-hot, 1-cycle pulse.
- req_x  in  N_REQ x 3 x D_BITS  operand vector x per requester.
- req_y  in  N_REQ x 3 x D_BITS  operand vector y per requester.
- dot_x  out  3 x D_BITS  latched x to the shared unit.
- dot_y  out  3 x D_BITS  latched y to the shared unit.
- dot_in_empty  out  1  low while latched operands await consumption.
- dot_in_rd_en  in  1  shared unit consumed operands.
- dot_out  in  D_BITS  shared unit result (valid while !dot_out_empty).
- dot_out_empty  in  1  shared unit output FIFO empty.
- dot_out_rd_en  out  1  pop shared unit output.
- res_dout  out  D_BITS  registered result, common to all requesters.
- res_full  in  N_REQ  per-requester result FIFO full.
- res_wr_en  out  N_REQ  per-requester result write, one-hot.
- busy  out  1  tag FIFO non-empty or issue FSM not in ARB.
- err_orphan  out  1  sticky: result arrived with no tag outstanding.

Behaviour:
- Reset (async, any state): both FSMs to initial states; tag FIFO empty; rr pointer = 0; `dot_x`/`dot_y`/`res_dout` = 0; `dot_in_empty`=1; all `rd_en`/`wr_en` = 0; `busy`=0; `err_orphan`=0. In-flight operations are discarded; the bench resets the dot unit simultaneously.
- Issue FSM, states ARB and HOLD:
  - ARB, grant conditions: among `i` with `req_empty[i]==0`, pick the first at or after the rr pointer (wrapping modulo N_REQ). Grant only if the tag FIFO is not full.
  - ARB, on grant g, same cycle: `req_rd_en[g]`=1; latch `req_x[g]`/`req_y[g]` into `dot_x`/`dot_y`; push g to the tag FIFO; rr pointer <= (g+1) mod N_REQ; next state HOLD.
  - ARB, no grant: stay in ARB; pointer unchanged.
  - HOLD: `dot_in_empty`=0, operands held stable. When `dot_in_rd_en`=1, go to ARB (`dot_in_empty` is 1 from the next cycle).
  - Throughput: at most one issue per 2 cycles. Latency from `req_empty` falling to `dot_in_empty` falling: 1 cycle.
- Return FSM, states RIDLE and RWRITE:
  - RIDLE: if `!dot_out_empty` and the tag FIFO is not empty, then `dot_out_rd_en`=1, `res_dout` <= `dot_out`, pop the tag into `res_tag`, next state RWRITE.
  - RIDLE, orphan case: if `!dot_out_empty` and the tag FIFO is empty, set `err_orphan` (sticky until reset), do not pop, stay in RIDLE.
  - RWRITE: `res_wr_en[res_tag]`=1 in every cycle where `res_full[res_tag]`==0, then go to RIDLE. While full, hold `res_dout` and `res_tag`. Other requesters' fullness is irrelevant.
- Ordering: results return strictly in issue order. The dot unit is in-order, so tag order is the correct mapping.
- Tag FIFO: a push (ARB grant) and a pop (RIDLE) in the same cycle are both honoured and the count is unchanged. Full when count == TAG_DEPTH.
- No width arithmetic: data passes through bit-exact. Tag width is clog2(N_REQ).
- A requester whose `req_empty` rises while in HOLD is unaffected; its operands were already latched.

Test Plan:
- Single op: req 1 offers x=(0x10000,0x20000,0x30000), y=(0x10000,0x10000,0x10000) (Q16) -> `req_rd_en[1]` pulses once; `res_wr_en[1]` pulses with `res_dout`=0x60000; no other `wr_en` fires; `busy` returns to 0.
- Round robin: all 4 requesters hold 2 ops each, operands distinct per requester -> grant order 0,1,2,3,0,1,2,3; each result lands on the matching `res_wr_en` index with the correct value.
- Backpressure: `res_full[2]`=1 for 20 cycles while req 2 and req 3 results are pending -> `res_dout` is held, no `wr_en` fires, and req 3's result waits behind req 2's. After release, wr_en fires for 2 then 3, in order.
- Tag full: hold the dot unit's output (its `out_rd_en` path stalled by `res_full` all high) until 16 ops are issued -> no 17th grant and `req_rd_en` stays 0. The 17th issues only after the first pop.
- Orphan: force `dot_out_empty`=0 with no issued ops -> `err_orphan`=1 next cycle, `dot_out_rd_en` stays 0; `err_orphan` clears only on reset.
- Reset mid-op: assert reset in HOLD with 3 tags outstanding -> outputs return to reset values immediately. A fresh single op after release completes correctly to its requester.
